// File: rtl/axis_sample_framer.sv
// Packs pairs of 14-bit samples into 32-bit AXI4-Stream beats, frames them with tlast
// and buffers them in a small FIFO; dropped words are flagged and counted.
module axis_sample_framer #(
   parameter int FRAME_BEATS = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int CNT_W       = 16
) (
   input  logic                          clock_50,
   input  logic                          reset_n,
   input  logic [13:0]                   data_stand,
   input  logic                          sample_en,
   input  logic                          clear_ovf,
   input  logic                          m_axis_tready,
   output logic [31:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [CNT_W-1:0]              drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

   localparam logic [0:0] PH_EVEN = 1'b0;
   localparam logic [0:0] PH_ODD  = 1'b1;

   logic [0:0]        phase_q, phase_d;
   logic [13:0]       samp_a_q, samp_a_d;
   logic [31:0]       word_q, word_d;
   logic              pack_req_q, pack_req_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       level_q, level_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic [32:0]       mem_q [FIFO_DEPTH];
   logic [32:0]       head;
   logic              rd_en, wr_en, drop, full, tlast_bit;

   assign full      = (level_q == (AW+1)'(FIFO_DEPTH));
   assign rd_en     = (level_q != '0) && m_axis_tready;
   // A full FIFO still takes the word when the head leaves on the same edge.
   assign wr_en     = pack_req_q && (!full || rd_en);
   assign drop      = pack_req_q && !wr_en;
   assign tlast_bit = (beat_q == BW'(FRAME_BEATS - 1));

   always_comb begin
      phase_d    = phase_q;
      samp_a_d   = samp_a_q;
      word_d     = word_q;
      pack_req_d = 1'b0;
      if (sample_en) begin
         if (phase_q == PH_EVEN) begin
            samp_a_d = data_stand;
            phase_d  = PH_ODD;
         end else begin
            word_d     = {2'b00, data_stand, 2'b00, samp_a_q};
            pack_req_d = 1'b1;
            phase_d    = PH_EVEN;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      beat_d   = beat_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         beat_d   = tlast_bit ? '0 : beat_q + BW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // A drop on the same edge as clear_ovf wins, leaving a count of one.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (clear_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (clear_ovf) begin
            drop_cnt_d = CNT_W'(1);
         end else if (!(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         phase_q    <= PH_EVEN;
         samp_a_q   <= '0;
         word_q     <= '0;
         pack_req_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         beat_q     <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         phase_q    <= phase_d;
         samp_a_q   <= samp_a_d;
         word_q     <= word_d;
         pack_req_q <= pack_req_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         beat_q     <= beat_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge clock_50) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {tlast_bit, word_q};
      end
   end

   // Storage is not reset, so the head is masked while the FIFO is empty.
   assign head          = mem_q[rd_ptr_q];
   assign m_axis_tvalid = (level_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? head[31:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid ? head[32] : 1'b0;
   assign fifo_level    = level_q;
   assign overflow      = overflow_q;
   assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_axis_sample_framer.sv
// Directed bench for axis_sample_framer: packing, framing, back-pressure, overflow,
// clear priority and asynchronous reset; a second instance covers single-beat frames.
module tb_axis_sample_framer;

   logic        clock_50;
   logic        reset_n;
   logic [13:0] data_stand;
   logic        sample_en;
   logic        clear_ovf;
   logic        m_axis_tready;

   logic [31:0] tdata, tdata1;
   logic        tvalid, tvalid1;
   logic        tlast, tlast1;
   logic [4:0]  level;
   logic [1:0]  level1;
   logic        ovf, ovf1;
   logic [15:0] drops, drops1;

   logic [32:0] got_q[$];
   logic [32:0] got1_q[$];
   logic [32:0] exp_q[$];

   int checks;
   int failures;

   axis_sample_framer #(.FRAME_BEATS(8), .FIFO_DEPTH(16), .CNT_W(16)) u_dut (
      .clock_50(clock_50), .reset_n(reset_n), .data_stand(data_stand),
      .sample_en(sample_en), .clear_ovf(clear_ovf), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
      .fifo_level(level), .overflow(ovf), .drop_count(drops)
   );

   axis_sample_framer #(.FRAME_BEATS(1), .FIFO_DEPTH(2), .CNT_W(16)) u_dut1 (
      .clock_50(clock_50), .reset_n(reset_n), .data_stand(data_stand),
      .sample_en(sample_en), .clear_ovf(clear_ovf), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
      .fifo_level(level1), .overflow(ovf1), .drop_count(drops1)
   );

   // Clock and beat capture: inputs change 1 ns after a rising edge, so a beat seen
   // valid and ready at the falling edge is the one handed over at the next rising edge.
   initial clock_50 = 1'b0;
   always #5 clock_50 = ~clock_50;

   always @(negedge clock_50) begin
      if (tvalid && m_axis_tready) got_q.push_back({tlast, tdata});
      if (tvalid1 && m_axis_tready) got1_q.push_back({tlast1, tdata1});
   end

   function automatic logic [32:0] beat(input int a, input int b, input bit last);
      logic [13:0] sa, sb;
      sa = 14'(a);
      sb = 14'(b);
      return {last, 2'b00, sb, 2'b00, sa};
   endfunction

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock_50);
         #1;
      end
   endtask

   task automatic send(input int d);
      data_stand = 14'(d);
      sample_en  = 1'b1;
      step();
      sample_en  = 1'b0;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      sample_en     = 1'b0;
      clear_ovf     = 1'b0;
      m_axis_tready = 1'b0;
      data_stand    = '0;
      step(3);
      reset_n = 1'b1;
      step();
      got_q.delete();
      got1_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if ({tvalid, tlast, tdata} !== 34'h0) begin failures++;
         $display("FAIL reset_stream: got v=%b l=%b d=%h exp 0", tvalid, tlast, tdata); end
      checks++; if ({level, ovf, drops} !== 22'h0) begin failures++;
         $display("FAIL reset_status: got lvl=%0d ovf=%b drops=%0d exp 0", level, ovf, drops); end
   endtask

   task automatic test_basic();
      do_reset();
      m_axis_tready = 1'b1;
      send(14'h0001);
      send(14'h0002);
      checks++; if (tvalid !== 1'b0) begin failures++;
         $display("FAIL basic_latency_early: got tvalid=%b exp 0", tvalid); end
      step();
      checks++; if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 32'h0002_0001}) begin failures++;
         $display("FAIL basic_first_beat: got v=%b l=%b d=%h exp v=1 l=0 d=00020001", tvalid, tlast, tdata); end
      send(14'h0003);
      send(14'h3FFF);
      step(4);
      exp_q = '{beat(1, 2, 0), beat(3, 14'h3FFF, 0)};
      checks++; if (got_q.size() !== 2) begin failures++;
         $display("FAIL basic_count: got %0d beats exp 2", got_q.size()); end
      for (int j = 0; j < 2 && j < got_q.size(); j++) begin
         checks++; if (got_q[j] !== exp_q[j]) begin failures++;
            $display("FAIL basic_beat%0d: got %h exp %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_frame();
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 32; i++) send(16 + i);
      step(4);
      for (int j = 0; j < 16; j++) exp_q.push_back(beat(16 + 2*j, 17 + 2*j, (j % 8) == 7));
      checks++; if (got_q.size() !== 16) begin failures++;
         $display("FAIL frame_count: got %0d beats exp 16", got_q.size()); end
      for (int j = 0; j < 16 && j < got_q.size(); j++) begin
         checks++; if (got_q[j] !== exp_q[j]) begin failures++;
            $display("FAIL frame_beat%0d: got %h exp %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 34; i++) send(100 + i);
      step(2);
      checks++; if (level !== 5'd16) begin failures++;
         $display("FAIL ovf_level: got %0d exp 16", level); end
      checks++; if ({ovf, drops} !== {1'b1, 16'd1}) begin failures++;
         $display("FAIL ovf_flag: got ovf=%b drops=%0d exp ovf=1 drops=1", ovf, drops); end
      step(5);
      checks++; if ({tvalid, tdata} !== {1'b1, 32'h0065_0064}) begin failures++;
         $display("FAIL ovf_head_hold: got v=%b d=%h exp v=1 d=00650064", tvalid, tdata); end
      m_axis_tready = 1'b1;
      step(20);
      m_axis_tready = 1'b0;
      for (int j = 0; j < 16; j++) exp_q.push_back(beat(100 + 2*j, 101 + 2*j, j == 7 || j == 15));
      checks++; if (got_q.size() !== 16) begin failures++;
         $display("FAIL ovf_drain_count: got %0d beats exp 16", got_q.size()); end
      for (int j = 0; j < 16 && j < got_q.size(); j++) begin
         checks++; if (got_q[j] !== exp_q[j]) begin failures++;
            $display("FAIL ovf_beat%0d: got %h exp %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_full_pop_write();
      do_reset();
      for (int i = 0; i < 32; i++) send(200 + i);
      step(2);
      checks++; if (level !== 5'd16) begin failures++;
         $display("FAIL fpw_prefill: got %0d exp 16", level); end
      send(232);
      send(233);
      m_axis_tready = 1'b1;
      step();
      m_axis_tready = 1'b0;
      checks++; if ({level, ovf, drops} !== {5'd16, 1'b0, 16'd0}) begin failures++;
         $display("FAIL fpw_status: got lvl=%0d ovf=%b drops=%0d exp 16/0/0", level, ovf, drops); end
      m_axis_tready = 1'b1;
      step(20);
      m_axis_tready = 1'b0;
      for (int j = 0; j < 17; j++) exp_q.push_back(beat(200 + 2*j, 201 + 2*j, j == 7 || j == 15));
      checks++; if (got_q.size() !== 17) begin failures++;
         $display("FAIL fpw_count: got %0d beats exp 17", got_q.size()); end
      for (int j = 0; j < 17 && j < got_q.size(); j++) begin
         checks++; if (got_q[j] !== exp_q[j]) begin failures++;
            $display("FAIL fpw_beat%0d: got %h exp %h", j, got_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_clear();
      do_reset();
      for (int i = 0; i < 36; i++) send(300 + i);
      step();
      checks++; if ({ovf, drops} !== {1'b1, 16'd2}) begin failures++;
         $display("FAIL clr_two_drops: got ovf=%b drops=%0d exp 1/2", ovf, drops); end
      send(400);
      send(401);
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      checks++; if ({ovf, drops} !== {1'b1, 16'd1}) begin failures++;
         $display("FAIL clr_with_drop: got ovf=%b drops=%0d exp 1/1", ovf, drops); end
      step();
      clear_ovf = 1'b1;
      step();
      clear_ovf = 1'b0;
      checks++; if ({ovf, drops} !== {1'b0, 16'd0}) begin failures++;
         $display("FAIL clr_alone: got ovf=%b drops=%0d exp 0/0", ovf, drops); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 11; i++) send(500 + i);
      step(2);
      checks++; if ({tvalid, level} !== {1'b1, 5'd5}) begin failures++;
         $display("FAIL ares_prefill: got v=%b lvl=%0d exp 1/5", tvalid, level); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if ({tvalid, tlast, tdata, level, ovf, drops} !== 56'h0) begin failures++;
         $display("FAIL ares_immediate: got v=%b l=%b d=%h lvl=%0d ovf=%b drops=%0d exp 0",
                  tvalid, tlast, tdata, level, ovf, drops); end
      step();
      reset_n = 1'b1;
      step();
      got_q.delete();
      m_axis_tready = 1'b1;
      send(14'h0AAA);
      send(14'h0555);
      step(4);
      checks++; if (got_q.size() !== 1) begin failures++;
         $display("FAIL ares_count: got %0d beats exp 1", got_q.size()); end
      checks++; if (got_q.size() > 0 && got_q[0] !== 33'h0_0555_0AAA) begin failures++;
         $display("FAIL ares_beat: got %h exp 005550aaa", got_q[0]); end
   endtask

   task automatic test_frame_one();
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) send(600 + i);
      step(4);
      for (int j = 0; j < 3; j++) exp_q.push_back(beat(600 + 2*j, 601 + 2*j, 1'b1));
      checks++; if (got1_q.size() !== 3) begin failures++;
         $display("FAIL f1_count: got %0d beats exp 3", got1_q.size()); end
      for (int j = 0; j < 3 && j < got1_q.size(); j++) begin
         checks++; if (got1_q[j] !== exp_q[j]) begin failures++;
            $display("FAIL f1_beat%0d: got %h exp %h", j, got1_q[j], exp_q[j]); end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      test_reset();
      test_basic();
      test_frame();
      test_overflow();
      test_full_pop_write();
      test_clear();
      test_async_reset();
      test_frame_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_sample_framer.md
Name: axis_sample_framer

Overview:
- Consumer stage for the 14-bit resynchronised sample stream `data_stand`, which arrives already in the `clock_50` domain.
- Packs pairs of samples into 32-bit AXI4-Stream beats and marks every `FRAME_BEATS`-th beat with `tlast`.
- Buffers beats in a small synchronous FIFO so that downstream back-pressure is absorbed.
- Overflow is reported through a sticky flag and a drop counter.

Parameters:
- `FRAME_BEATS`, 8, number of accepted beats per frame; `tlast` is set on the last one; legal range 1..256.
- `FIFO_DEPTH`, 16, FIFO entries; must be a power of 2, minimum 2.
- `CNT_W`, 16, width of `drop_count`.

Ports:
- `clock_50` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous reset, active-low.
- `data_stand` in 14: sample from the upstream resync stage.
- `sample_en` in 1: `data_stand` is valid this cycle.
- `clear_ovf` in 1: one-cycle pulse; clears `overflow` and `drop_count`.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out 32: packed beat.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tlast` out 1: last beat of a frame.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `overflow` out 1: sticky; set when a packed word was dropped.
- `drop_count` out CNT_W: number of dropped words; saturates at all-ones.

Behaviour:
- Reset (`reset_n`=0, asynchronous, takes effect at any point in the cycle):
  - FIFO emptied; pair phase set to EVEN; beat counter set to 0.
  - All outputs are 0: `tdata`, `tvalid`, `tlast`, `fifo_level`, `overflow`, `drop_count`.
  - A partially collected pair is discarded.
  - Release is at the first rising edge with `reset_n`=1.
- Pair packer, two states:
  - EVEN: when `sample_en`=1, latch `data_stand` as sample A and go to ODD.
  - ODD: when `sample_en`=1, latch sample B, raise the internal `pack_req` for exactly one cycle, and go to EVEN.
  - `sample_en`=0 leaves the state unchanged. There is no timeout; a pair may span any number of cycles.
- Word format: `tdata[13:0]`=A, `tdata[15:14]`=2'b00, `tdata[29:16]`=B, `tdata[31:30]`=2'b00.
- Latency: sample B accepted at edge k → word written into the FIFO at edge k+1 → with the FIFO previously empty, `tvalid`=1 from edge k+1.
- Write acceptance at the edge where `pack_req`=1:
  - The write is accepted if `fifo_level` < `FIFO_DEPTH`, or if a read (`tvalid` & `tready`) happens on the same edge. A full FIFO with a simultaneous read accepts the write and stays full.
  - If the write is accepted: store `{tlast_bit, word}`. `tlast_bit`=1 when beat counter = `FRAME_BEATS`-1; the beat counter then wraps to 0, otherwise it increments.
  - If the write is rejected: the word is dropped, `overflow`←1, `drop_count` increments (saturating), and the beat counter is not advanced. Frame length therefore always counts delivered beats.
- Output side:
  - `m_axis_tvalid` = FIFO not empty. `tdata` and `tlast` are driven from the FIFO head.
  - A handshake (`tvalid` & `tready` at an edge) pops the head.
  - While `tvalid`=1 and `tready`=0, `tdata` and `tlast` hold stable. The AXI rule applies: `tvalid` never drops without a handshake.
  - `tvalid` does not depend combinationally on `tready`.
- `fifo_level`: registered; +1 on write only, -1 on read only, unchanged on simultaneous write+read.
- `clear_ovf`:
  - Clears `overflow` and `drop_count` at the edge.
  - If a drop occurs on the same edge, the drop wins: `overflow`=1 and `drop_count`=1.
- `sample_en` and `data_stand` are used only at edges. No other inputs are qualified.
- `FRAME_BEATS`=1: every beat has `tlast`=1.

Test Plan:
- Reset, then 4 `sample_en` pulses with `data_stand`=0x0001, 0x0002, 0x0003, 0x3FFF; `tready`=1 → two beats, 0x00020001 then 0x3FFF0003; first `tvalid` one edge after the 2nd sample; `tlast`=0.
- 16 consecutive samples (8 beats) with `tready`=1 and `FRAME_BEATS`=8 → `tlast`=1 only on beat 8; on the next 8 beats, `tlast`=1 on the 16th beat overall.
- Hold `tready`=0 and send 34 samples (17 words) → `fifo_level`=16, `overflow`=1, `drop_count`=1, `tvalid` stays 1 with head `tdata` stable. Then set `tready`=1 → exactly 16 beats are delivered, and `tlast` is on beat 8 and beat 16.
- FIFO full plus a simultaneous pop and `pack_req` → write accepted, `fifo_level` stays 16, no drop.
- `clear_ovf` pulse on the same edge as a drop → `overflow`=1, `drop_count`=1. A later `clear_ovf` with no drop → `overflow`=0, `drop_count`=0.
- Assert `reset_n`=0 mid-cycle with 1 sample pending and 5 entries queued → all outputs go to 0 immediately. After release, 2 samples 0x0AAA and 0x0555 → single beat 0x05550AAA, with no stale sample A.
